// File: rtl/instr_queue_if.sv
// Fetch-to-decode handshake bundle for the instruction queue.
// The master side is the driver/testbench; the slave side is the queue itself.
interface instr_queue_if #(
  parameter int unsigned AW = 2
);
  logic          flush;
  logic          in_valid;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc_4;
  logic [31:0]   out_instr;
  logic [AW:0]   count;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_pc_4, out_instr, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_pc_4, out_instr, count
  );
endinterface

// File: rtl/instr_queue.sv
// Circular FIFO of {pc, instr} pairs between fetch and decode.
// Head outputs read NOP values while empty; flush discards everything.
module instr_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic         clk,
  input  logic         rst,
  instr_queue_if.slave bus
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic [AW-1:0] w_rd_ptr_nxt;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW:0]   w_count_nxt;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_head_pc;

  // Ready/valid depend only on registered occupancy: a full queue refuses a push even while popping.
  assign w_in_ready  = (r_count < FullCount);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready && !bus.flush;
  assign w_pop       = w_out_valid && bus.out_ready && !bus.flush;

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    if (bus.flush) begin
      w_rd_ptr_nxt = '0;
      w_wr_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        w_count_nxt = r_count + (AW + 1)'(1);
      end else if (w_pop && !w_push) begin
        w_count_nxt = r_count - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= w_rd_ptr_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= bus.in_pc;
      r_instr_mem[r_wr_ptr] <= bus.in_instr;
    end
  end

  assign w_head_pc     = w_out_valid ? r_pc_mem[r_rd_ptr] : 32'h0000_0000;
  assign bus.out_pc    = w_head_pc;
  assign bus.out_pc_4  = w_head_pc + 32'd4;
  assign bus.out_instr = w_out_valid ? r_instr_mem[r_rd_ptr] : 32'h0000_0000;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue (DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_instr_queue;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  instr_queue_if #(.AW(2)) q_if ();

  instr_queue #(.DEPTH(4), .AW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (q_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_nop(input string tag);
    chk({tag, "_valid"}, 32'(q_if.out_valid), 32'd0);
    chk({tag, "_pc"}, q_if.out_pc, 32'h0000_0000);
    chk({tag, "_pc4"}, q_if.out_pc_4, 32'h0000_0004);
    chk({tag, "_instr"}, q_if.out_instr, 32'h0000_0000);
    chk({tag, "_count"}, 32'(q_if.count), 32'd0);
    chk({tag, "_in_ready"}, 32'(q_if.in_ready), 32'd1);
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic push(input logic [31:0] pc);
    q_if.in_valid = 1'b1;
    q_if.in_pc    = pc;
    q_if.in_instr = instr_of(pc);
    tick();
    q_if.in_valid = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b0;
    q_if.flush     = 1'b0;
    q_if.in_valid  = 1'b0;
    q_if.in_pc     = '0;
    q_if.in_instr  = '0;
    q_if.out_ready = 1'b0;

    // Reset state, before any clock edge.
    #3;
    chk_nop("reset");
    #9;
    rst = 1'b1;

    // First push after reset; no fall-through before the edge.
    q_if.in_valid = 1'b1;
    q_if.in_pc    = 32'h0000_3000;
    q_if.in_instr = 32'h3C01_0001;
    #0;
    chk("no_fallthrough", 32'(q_if.out_valid), 32'd0);
    tick();
    q_if.in_valid = 1'b0;
    chk("p1_valid", 32'(q_if.out_valid), 32'd1);
    chk("p1_pc", q_if.out_pc, 32'h0000_3000);
    chk("p1_pc4", q_if.out_pc_4, 32'h0000_3004);
    chk("p1_instr", q_if.out_instr, 32'h3C01_0001);
    chk("p1_count", 32'(q_if.count), 32'd1);

    // Fill to DEPTH; a further push is ignored.
    push(32'h0000_3004);
    push(32'h0000_3008);
    push(32'h0000_300C);
    chk("full_count", 32'(q_if.count), 32'd4);
    chk("full_in_ready", 32'(q_if.in_ready), 32'd0);
    push(32'h0000_3010);
    chk("ovf_count", 32'(q_if.count), 32'd4);
    chk("ovf_head", q_if.out_pc, 32'h0000_3000);

    // Drain; the first pop offers a push while full, which must be refused.
    q_if.out_ready = 1'b1;
    q_if.in_valid  = 1'b1;
    q_if.in_pc     = 32'h0000_3010;
    q_if.in_instr  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc", q_if.out_pc, 32'h0000_3000 + 32'(4 * i));
      tick();
      q_if.in_valid = 1'b0;
    end
    q_if.out_ready = 1'b0;
    chk_nop("drained");

    // Streaming with one entry preloaded; pointers wrap twice.
    push(32'h0000_4000);
    q_if.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("stream_pc", q_if.out_pc, 32'h0000_4000 + 32'(4 * k));
      chk("stream_instr", q_if.out_instr, instr_of(32'h0000_4000 + 32'(4 * k)));
      chk("stream_count", 32'(q_if.count), 32'd1);
      q_if.in_valid = 1'b1;
      q_if.in_pc    = 32'h0000_4004 + 32'(4 * k);
      q_if.in_instr = instr_of(32'h0000_4004 + 32'(4 * k));
      tick();
    end
    q_if.in_valid = 1'b0;
    chk("stream_last", q_if.out_pc, 32'h0000_4028);
    tick();
    q_if.out_ready = 1'b0;
    chk_nop("stream_end");

    // Flush beats concurrent push and pop.
    push(32'h0000_5000);
    push(32'h0000_5004);
    push(32'h0000_5008);
    chk("pre_flush_count", 32'(q_if.count), 32'd3);
    q_if.flush     = 1'b1;
    q_if.out_ready = 1'b1;
    q_if.in_valid  = 1'b1;
    q_if.in_pc     = 32'h0000_500C;
    q_if.in_instr  = instr_of(32'h0000_500C);
    tick();
    q_if.flush     = 1'b0;
    q_if.in_valid  = 1'b0;
    q_if.out_ready = 1'b0;
    chk_nop("flush");
    push(32'h0000_6000);
    chk("post_flush_head", q_if.out_pc, 32'h0000_6000);
    chk("post_flush_count", 32'(q_if.count), 32'd1);
    q_if.out_ready = 1'b1;
    tick();
    q_if.out_ready = 1'b0;

    // out_pc_4 wraps modulo 2^32.
    push(32'hFFFF_FFFC);
    chk("wrap_pc4", q_if.out_pc_4, 32'h0000_0000);
    q_if.out_ready = 1'b1;
    tick();
    q_if.out_ready = 1'b0;

    // Asynchronous reset mid-operation on a full queue.
    push(32'h0000_7000);
    push(32'h0000_7004);
    push(32'h0000_7008);
    push(32'h0000_700C);
    chk("pre_rst_count", 32'(q_if.count), 32'd4);
    #2;
    rst = 1'b0;
    #1;
    chk_nop("async_rst");
    rst = 1'b1;
    push(32'h0000_3000);
    chk("post_rst_head", q_if.out_pc, 32'h0000_3000);
    chk("post_rst_count", 32'(q_if.count), 32'd1);
    q_if.out_ready = 1'b1;
    tick();

    // Popping an empty queue has no effect.
    for (int j = 0; j < 5; j++) begin
      tick();
      chk_nop("empty_pop");
    end
    q_if.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
